// File: rtl/rcv_drain_ctrl.sv
// UART receive drain controller: acknowledges each received byte once, buffers
// it with its parity bit in a small FIFO and counts framing/overrun events.
module rcv_drain_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [7:0]               rcv_rx_data,
  input  logic                     rcv_parity_bit,
  input  logic                     rcv_data_ready,
  input  logic                     rcv_framing_error,
  input  logic                     rcv_overrun_error,
  output logic                     rcv_data_read,
  output logic [7:0]               out_data,
  output logic                     out_parity,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         ferr_count,
  output logic [CNT_W-1:0]         ovr_count,
  input  logic                     clear_counts
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_t;

  state_t           state, state_nxt;
  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  logic             ferr_q, ovr_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt     = state;
    push          = 1'b0;
    rcv_data_read = 1'b0;
    case (state)
      IDLE: begin
        if (rcv_data_ready && fifo_count != FULL) begin
          push      = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        rcv_data_read = 1'b1;
        state_nxt     = WAIT_CLR;
      end
      WAIT_CLR: begin
        // Wait for the receiver to drop data_ready so one byte is written once.
        if (!rcv_data_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign out_parity = out_valid ? mem[rd_ptr][8]   : 1'b0;

  // NOTE: storage is not reset; stale entries are never visible because the
  // head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rcv_parity_bit, rcv_rx_data};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Error event counters: count rising edges, saturate, clear wins over increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_count <= '0;
      ovr_count  <= '0;
    end else begin
      ferr_q <= rcv_framing_error;
      ovr_q  <= rcv_overrun_error;
      if (clear_counts) begin
        ferr_count <= '0;
        ovr_count  <= '0;
      end else begin
        if (rcv_framing_error && !ferr_q && ferr_count != CNT_MAX)
          ferr_count <= ferr_count + CNT_W'(1);
        if (rcv_overrun_error && !ovr_q && ovr_count != CNT_MAX)
          ovr_count <= ovr_count + CNT_W'(1);
      end
    end
  end

endmodule
